// File: rtl/sme2_za_ldst.sv
// ZA array load/store sequencer: moves rows between beat streams and the core's ZA port.
// Loads write one row per beat; stores read a row, then offer it on the store stream.
module sme2_za_ldst #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              za_enabled,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_store,
    input  logic [ADDR_W-1:0] cmd_row,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic [DATA_W-1:0] st_data,
    output logic [ADDR_W-1:0] za_addr,
    output logic [DATA_W-1:0] za_wdata,
    output logic              za_write_en,
    input  logic [DATA_W-1:0] za_rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ST_REQ  = 3'd2,
        ST_WAIT = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] row_ptr, row_nxt;
    logic [ADDR_W-1:0] remaining, remaining_nxt;
    logic [ADDR_W-1:0] wr_addr;
    logic              cmd_fire, ld_fire, st_fire, abort;
    logic              done_nxt, err_nxt;

    assign cmd_ready = (state == IDLE);
    assign ld_ready  = (state == LOAD);
    assign st_valid  = (state == ST_OUT);
    assign busy      = (state != IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign ld_fire   = ld_valid && ld_ready;
    assign st_fire   = st_valid && st_ready;
    assign abort     = busy && !za_enabled;

    // Read address is only presented during ST_REQ; otherwise show the last write address.
    assign za_addr = (state == ST_REQ) ? row_ptr : wr_addr;

    always_comb begin
        state_nxt     = state;
        row_nxt       = row_ptr;
        remaining_nxt = remaining;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    if (!za_enabled) begin
                        err_nxt = 1'b1;
                    end else begin
                        row_nxt       = cmd_row;
                        remaining_nxt = cmd_len;
                        state_nxt     = cmd_store ? ST_REQ : LOAD;
                    end
                end
            end
            LOAD: begin
                if (ld_fire) begin
                    row_nxt = row_ptr + ADDR_W'(1);
                    if (remaining == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        remaining_nxt = remaining - ADDR_W'(1);
                    end
                end
            end
            ST_REQ:  state_nxt = ST_WAIT;
            ST_WAIT: state_nxt = ST_OUT;
            ST_OUT: begin
                if (st_fire) begin
                    row_nxt = row_ptr + ADDR_W'(1);
                    if (remaining == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        remaining_nxt = remaining - ADDR_W'(1);
                        state_nxt     = ST_REQ;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Losing ZA wins over completion so done and err can never coincide.
        if (abort) begin
            state_nxt = IDLE;
            done_nxt  = 1'b0;
            err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            row_ptr     <= '0;
            remaining   <= '0;
            wr_addr     <= '0;
            za_wdata    <= '0;
            za_write_en <= 1'b0;
            st_data     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            row_ptr     <= row_nxt;
            remaining   <= remaining_nxt;
            za_write_en <= ld_fire;
            done        <= done_nxt;
            err         <= err_nxt;
            if (ld_fire) begin
                wr_addr  <= row_ptr;
                za_wdata <= ld_data;
            end
            if (state == ST_WAIT) begin
                st_data <= za_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sme2_za_ldst.sv
// Directed bench for sme2_za_ldst: loads, stores with backpressure, disabled ZA,
// mid-transfer abort and reset during a store, with a row-indexed ZA read model.
module tb_sme2_za_ldst;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         za_enabled;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_store;
    logic [7:0]   cmd_row;
    logic [7:0]   cmd_len;
    logic         ld_valid;
    logic         ld_ready;
    logic [511:0] ld_data;
    logic         st_valid;
    logic         st_ready;
    logic [511:0] st_data;
    logic [7:0]   za_addr;
    logic [511:0] za_wdata;
    logic         za_write_en;
    logic [511:0] za_rdata;
    logic         busy;
    logic         done;
    logic         err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_done = 0, n_err = 0, n_dw = 0, n_busy = 0, n_both = 0;
    logic [7:0]   wa[$];
    logic [511:0] wd[$];
    int           wcyc[$];
    logic [511:0] sd[$];
    int           scyc[$];

    sme2_za_ldst dut (
        .clk(clk), .rst_n(rst_n), .za_enabled(za_enabled),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
        .cmd_row(cmd_row), .cmd_len(cmd_len),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
        .za_addr(za_addr), .za_wdata(za_wdata), .za_write_en(za_write_en),
        .za_rdata(za_rdata), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [511:0] za_val(input logic [7:0] a);
        return {16{{24'hC0FFEE, a}}};
    endfunction

    // ZA read port model: data valid one cycle after the address.
    always @(posedge clk) za_rdata <= za_val(za_addr);

    always @(negedge clk) begin
        if (za_write_en) begin
            wa.push_back(za_addr);
            wd.push_back(za_wdata);
            wcyc.push_back(cyc);
        end
        if (st_valid && st_ready) begin
            sd.push_back(st_data);
            scyc.push_back(cyc);
        end
        if (done) n_done++;
        if (err) n_err++;
        if (done && za_write_en) n_dw++;
        if (done && err) n_both++;
        if (busy) n_busy++;
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic store, input logic [7:0] row, input logic [7:0] len);
        cmd_valid = 1'b1;
        cmd_store = store;
        cmd_row   = row;
        cmd_len   = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic load_beats(input int n, input logic [511:0] base);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = base + 512'(i);
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
    endtask

    task automatic wait_st_valid(input string tag);
        int k;
        k = 0;
        while (!st_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (!st_valid) check({tag, "_timeout"}, 0, 1);
    endtask

    int b, bd, be, bs, bb;
    logic [511:0] d0;
    int unstable;

    initial begin
        rst_n = 1'b0; za_enabled = 1'b1; cmd_valid = 1'b0; cmd_store = 1'b0;
        cmd_row = '0; cmd_len = '0; ld_valid = 1'b0; ld_data = '0; st_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_st_valid", st_valid, 0);
        check("rst_write_en", za_write_en, 0);
        check("rst_za_addr", za_addr, 0);
        check("rst_za_wdata", za_wdata, 0);
        check("rst_st_data", st_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_cmd_ready", cmd_ready, 1);

        // single-row load
        b = wa.size(); bd = n_done; be = n_err; bb = n_dw;
        issue(1'b0, 8'h01, 8'h00);
        load_beats(1, {16{32'hDEADBEEF}});
        repeat (3) @(posedge clk); #1;
        check("l1_writes", wa.size() - b, 1);
        check("l1_addr", wa[b], 8'h01);
        check("l1_data", wd[b], {16{32'hDEADBEEF}});
        check("l1_done", n_done - bd, 1);
        check("l1_done_with_write", n_dw - bb, 1);
        check("l1_err", n_err - be, 0);

        // four rows wrapping past 0xFF
        b = wa.size(); bd = n_done; bb = n_dw;
        issue(1'b0, 8'hFE, 8'h03);
        load_beats(4, {16{32'h12340000}});
        repeat (3) @(posedge clk); #1;
        check("l4_writes", wa.size() - b, 4);
        check("l4_addr0", wa[b], 8'hFE);
        check("l4_addr1", wa[b+1], 8'hFF);
        check("l4_addr2", wa[b+2], 8'h00);
        check("l4_addr3", wa[b+3], 8'h01);
        check("l4_data3", wd[b+3], {16{32'h12340000}} + 512'd3);
        check("l4_consecutive", wcyc[b+3] - wcyc[b], 3);
        check("l4_done", n_done - bd, 1);
        check("l4_done_with_last", n_dw - bb, 1);

        // two-row store with backpressure on the first beat
        b = wa.size(); bd = n_done; bs = sd.size();
        st_ready = 1'b0;
        issue(1'b1, 8'h10, 8'h01);
        wait_st_valid("s2");
        d0 = st_data;
        check("s2_first_data", d0, za_val(8'h10));
        unstable = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (st_data !== d0 || !st_valid) unstable++;
        end
        check("s2_hold_stable", unstable, 0);
        st_ready = 1'b1;
        for (int k = 0; k < 30 && n_done == bd; k++) begin
            @(posedge clk); #1;
        end
        st_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("s2_beats", sd.size() - bs, 2);
        check("s2_beat0", sd[bs], za_val(8'h10));
        check("s2_beat1", sd[bs+1], za_val(8'h11));
        check("s2_rate", scyc[bs+1] - scyc[bs], 3);
        check("s2_no_write", wa.size() - b, 0);
        check("s2_done", n_done - bd, 1);

        // command while ZA disabled
        b = wa.size(); be = n_err; bd = n_done; bs = n_busy;
        za_enabled = 1'b0;
        issue(1'b0, 8'h05, 8'h02);
        ld_valid = 1'b1;
        repeat (4) @(posedge clk); #1;
        ld_valid = 1'b0;
        za_enabled = 1'b1;
        check("dis_err", n_err - be, 1);
        check("dis_no_write", wa.size() - b, 0);
        check("dis_busy", n_busy - bs, 0);
        check("dis_done", n_done - bd, 0);

        // ZA lost after the third beat of an 8-row load
        b = wa.size(); be = n_err; bd = n_done;
        issue(1'b0, 8'h40, 8'h07);
        load_beats(3, {16{32'hA0000000}});
        za_enabled = 1'b0;
        @(posedge clk); #1;
        ld_valid = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("ab_busy", busy, 0);
        check("ab_cmd_ready", cmd_ready, 1);
        check("ab_ld_ready", ld_ready, 0);
        ld_valid = 1'b0;
        za_enabled = 1'b1;
        @(posedge clk); #1;
        check("ab_writes", wa.size() - b, 3);
        check("ab_addr2", wa[b+2], 8'h42);
        check("ab_err", n_err - be, 1);
        check("ab_done", n_done - bd, 0);

        // reset while a store row is waiting on the stream
        be = n_err; bd = n_done; b = wa.size();
        st_ready = 1'b0;
        issue(1'b1, 8'h20, 8'h02);
        wait_st_valid("rs");
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rs_st_valid", st_valid, 0);
        check("rs_busy", busy, 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk); #1;
        check("rs_done", n_done - bd, 0);
        check("rs_err", n_err - be, 0);
        check("rs_no_write", wa.size() - b, 0);
        check("done_err_overlap", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sme2_za_ldst.md
SME2_ZA_LDST -- requirements
Module: sme2_za_ldst

Interface
REQ-001 SHALL have parameter DATA_W, default 512, meaning ZA row width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning ZA row address width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port za_enabled  input  1  ZA storage enabled by core (streaming mode).
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-008 SHALL have port cmd_store  input  1  0 = load (stream into ZA), 1 = store (ZA to stream).
REQ-009 SHALL have port cmd_row  input  ADDR_W  first ZA row.
REQ-010 SHALL have port cmd_len  input  ADDR_W  row count minus one (0 = 1 row, 255 = 256 rows).
REQ-011 SHALL have ports ld_valid input 1 / ld_ready output 1 / ld_data input DATA_W: load beat stream.
REQ-012 SHALL have ports st_valid output 1 / st_ready input 1 / st_data output DATA_W: store beat stream.
REQ-013 SHALL have ports za_addr output ADDR_W / za_wdata output DATA_W / za_write_en output 1: ZA write/read port to core.
REQ-014 SHALL have port za_rdata  input  DATA_W  ZA read data, valid exactly one cycle after za_addr is presented.
REQ-015 SHALL have ports busy output 1 (FSM not IDLE), done output 1 (1-cycle pulse), err output 1 (1-cycle pulse).

Function
REQ-016 FSM states SHALL be IDLE, LOAD, ST_REQ, ST_WAIT, ST_OUT.
REQ-017 cmd_ready SHALL equal 1 only in IDLE; a command is accepted on cmd_valid && cmd_ready.
REQ-018 On acceptance with za_enabled=0: no transfer, stay IDLE, err pulses next cycle.
REQ-019 On acceptance with za_enabled=1: latch cmd_row to row pointer, cmd_len to remaining counter; go LOAD if cmd_store=0, else ST_REQ.
REQ-020 LOAD: ld_ready=1; each ld_valid && ld_ready beat SHALL, next cycle, drive za_write_en=1, za_addr=row pointer, za_wdata=ld_data (registered, 1-cycle latency).
REQ-021 za_write_en SHALL be 0 in every cycle not following an accepted load beat; never asserted in store states.
REQ-022 ST_REQ: za_addr = row pointer for one cycle, then ST_WAIT.
REQ-023 ST_WAIT: capture za_rdata into st_data register, go ST_OUT.
REQ-024 ST_OUT: st_valid=1, st_data held stable until st_valid && st_ready; then advance to ST_REQ or finish.
REQ-025 Row pointer SHALL increment by 1 per transferred row, modulo 2^ADDR_W (255 wraps to 0).
REQ-026 After the beat with remaining counter = 0: return IDLE; done pulses in the following cycle (same cycle as last za_write_en for loads).
REQ-027 If za_enabled falls while busy: abort at next edge, return IDLE, err pulses, ld_ready/st_valid deassert; a load beat accepted in the same cycle SHALL still be written; no further writes; done not asserted.
REQ-028 done and err SHALL never be high in the same cycle.
REQ-029 Store throughput: one row per 3 cycles with st_ready held 1; load: one row per cycle with ld_valid held 1.

Reset
REQ-030 With rst_n=0 at a rising edge: state IDLE; cmd_ready=1 after release; ld_ready, st_valid, za_write_en, busy, done, err = 0; za_addr, za_wdata, st_data = 0; counters cleared.
REQ-031 Reset mid-operation SHALL abandon the transfer with no done/err pulse and no further ZA write.

Verification
REQ-032 Load row=0x01 len=0, ld_data=0xDEADBEEF... -> one za_write_en cycle, za_addr=0x01, za_wdata matches, done next cycle.
REQ-033 Load row=0xFE len=3, back-to-back beats -> writes to 0xFE,0xFF,0x00,0x01 in 4 consecutive cycles, done once.
REQ-034 Store row=0x10 len=1, ZA model returns row-indexed data, st_ready low 5 cycles on first beat -> st_data stable, 2 beats in order, za_write_en never 1.
REQ-035 Command with za_enabled=0 -> cmd accepted, err 1-cycle pulse, no za_write_en, busy stays 0.
REQ-036 Load len=7, za_enabled dropped after 3rd beat -> exactly 3 writes, err pulse, IDLE, cmd_ready=1.
REQ-037 rst_n=0 during store ST_OUT -> next cycle st_valid=0, busy=0, no done.
